// File: rtl/lsu_hs.sv
// Load/store unit between a CPU request/response port and a single-beat word memory.
// It handles lane positioning, misaligned split/fault, load extension and per-phase timeouts.
module lsu_hs #(
  parameter int ADDR_W         = 16,
  parameter bit MISALIGN_SPLIT = 1'b1,
  parameter int TIMEOUT        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT);

  // Handshakes: a transfer happens on a rising edge where valid && ready (req_*, rsp_*)
  // or mem_req && mem_gnt; the offering side holds its payload stable until then.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_we, w_we_nxt;
  logic [1:0]          r_size, w_size_nxt;
  logic                r_uns, w_uns_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic                r_cross, w_cross_nxt;
  logic                r_phase, w_phase_nxt;
  logic [31:0]         r_buf0, w_buf0_nxt;
  logic [31:0]         r_buf1, w_buf1_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic [31:0]         r_rsp_rdata, w_rsp_rdata_nxt;

  // Decode of the incoming request (used only at acceptance).
  logic [1:0] w_in_off;
  logic       w_in_mis;
  logic       w_in_cross;
  logic       w_in_fault;

  assign w_in_off   = req_addr[1:0];
  assign w_in_mis   = ((req_size == 2'b01) && w_in_off[0]) ||
                      ((req_size == 2'b10) && (w_in_off != 2'b00));
  assign w_in_cross = ((req_size == 2'b01) && (w_in_off == 2'b11)) ||
                      ((req_size == 2'b10) && (w_in_off != 2'b00));
  assign w_in_fault = (req_size == 2'b11) || (w_in_mis && (MISALIGN_SPLIT == 1'b0));

  // Lane placement of the latched request across a two-word window.
  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [7:0]        w_be8;
  logic [63:0]       w_wd64;
  logic [ADDR_W-1:0] w_word;
  logic [ADDR_W-1:0] w_phase_addr;

  assign w_off        = r_addr[1:0];
  assign w_mask       = (r_size == 2'b00) ? 4'b0001 :
                        (r_size == 2'b01) ? 4'b0011 : 4'b1111;
  assign w_be8        = {4'b0000, w_mask} << w_off;
  assign w_wd64       = {32'h0, r_wdata} << {w_off, 3'b000};
  assign w_word       = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_phase_addr = w_word + {{(ADDR_W-3){1'b0}}, r_phase, 2'b00};

  // Load result, using the arriving beat for the phase being completed.
  logic [31:0] w_lo;
  logic [31:0] w_hi;
  logic [63:0] w_sh64;
  logic [31:0] w_sh;
  logic [31:0] w_ld;

  assign w_lo   = r_phase ? r_buf0 : mem_rdata;
  assign w_hi   = r_phase ? mem_rdata : r_buf1;
  assign w_sh64 = {w_hi, w_lo} >> {w_off, 3'b000};
  assign w_sh   = w_sh64[31:0];

  always_comb begin
    w_ld = w_sh;
    case (r_size)
      2'b00:   w_ld = r_uns ? {24'h0, w_sh[7:0]}   : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ld = r_uns ? {16'h0, w_sh[15:0]}  : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_we_nxt        = r_we;
    w_size_nxt      = r_size;
    w_uns_nxt       = r_uns;
    w_wdata_nxt     = r_wdata;
    w_cross_nxt     = r_cross;
    w_phase_nxt     = r_phase;
    w_buf0_nxt      = r_buf0;
    w_buf1_nxt      = r_buf1;
    w_cnt_nxt       = r_cnt;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_nxt      = req_addr;
          w_we_nxt        = req_we;
          w_size_nxt      = req_size;
          w_uns_nxt       = req_unsigned;
          w_wdata_nxt     = req_wdata;
          w_cross_nxt     = w_in_cross;
          w_phase_nxt     = 1'b0;
          w_buf0_nxt      = 32'h0;
          w_buf1_nxt      = 32'h0;
          w_cnt_nxt       = '0;
          w_rsp_rdata_nxt = 32'h0;
          w_rsp_err_nxt   = w_in_fault;
          w_state_nxt     = w_in_fault ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          w_cnt_nxt = '0;
          if (!r_we) begin
            w_state_nxt = S_WAIT_RD;
          end else if (r_cross && !r_phase) begin
            w_phase_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RESP;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
          w_rsp_err_nxt = 1'b1;
          w_state_nxt   = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_RD: begin
        if (mem_rvalid) begin
          w_cnt_nxt = '0;
          if (r_phase) w_buf1_nxt = mem_rdata;
          else         w_buf0_nxt = mem_rdata;
          if (r_cross && !r_phase) begin
            w_phase_nxt = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_rsp_rdata_nxt = w_ld;
            w_state_nxt     = S_RESP;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
          w_rsp_err_nxt = 1'b1;
          w_state_nxt   = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_wdata     <= 32'h0;
      r_cross     <= 1'b0;
      r_phase     <= 1'b0;
      r_buf0      <= 32'h0;
      r_buf1      <= 32'h0;
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_we        <= w_we_nxt;
      r_size      <= w_size_nxt;
      r_uns       <= w_uns_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cross     <= w_cross_nxt;
      r_phase     <= w_phase_nxt;
      r_buf0      <= w_buf0_nxt;
      r_buf1      <= w_buf1_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  // Memory outputs are forced to zero outside REQ so nothing leaks after a timeout or abort.
  assign req_ready = (r_state == S_IDLE) && !rst;
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? w_phase_addr : '0;
  assign mem_be    = mem_req ? (r_phase ? w_be8[7:4] : w_be8[3:0]) : 4'b0000;
  assign mem_wdata = mem_req ? (r_phase ? w_wd64[63:32] : w_wd64[31:0]) : 32'h0;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

endmodule
